// File: rtl/tl_xing_pkg.sv
// Shared TL-UL field layout and opcodes for the crossing arbiter.
// Field offsets are counted from bit 0 (data) upward.
package tl_xing_pkg;

    localparam int DEF_SRC_W = 8;

    // A: {opcode, size, source, address, mask, data}.
    localparam int A_SRC_LSB = 32 + 4 + 32;
    localparam int A_W = 3 + 2 + DEF_SRC_W + A_SRC_LSB;

    // D: {opcode, size, source, denied, data}.
    localparam int D_SRC_LSB = 1 + 32;
    localparam int D_W = 3 + 2 + DEF_SRC_W + D_SRC_LSB;

    localparam logic [2:0] OP_PUT_FULL      = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL   = 3'd1;
    localparam logic [2:0] OP_GET           = 3'd4;
    localparam logic [2:0] OP_ACCESS_ACK    = 3'd0;
    localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;

    typedef struct packed {
        logic [2:0]           opcode;
        logic [1:0]           size;
        logic [DEF_SRC_W-1:0] source;
        logic [31:0]          address;
        logic [3:0]           mask;
        logic [31:0]          data;
    } tl_a_t;

    typedef struct packed {
        logic [2:0]           opcode;
        logic [1:0]           size;
        logic [DEF_SRC_W-1:0] source;
        logic                 denied;
        logic [31:0]          data;
    } tl_d_t;

endpackage

// File: rtl/rr_arbiter_core.sv
// Rotating-priority pick over NREQ requests with its own round-robin pointer.
// The pointer moves one past the index that was actually served.
module rr_arbiter_core #(
    parameter int NREQ = 2,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic              advance,
    input  logic [IDX_W-1:0]  advIdx,
    output logic              pickVld,
    output logic [IDX_W-1:0]  pickIdx
);

    logic [IDX_W-1:0] rrPtr;

    always_ff @(posedge clock) begin
        if (reset) begin
            rrPtr <= '0;
        end else if (advance) begin
            rrPtr <= (int'(advIdx) == NREQ - 1) ? '0 : advIdx + 1'b1;
        end
    end

    // Scan from the farthest offset down so the nearest eligible index wins.
    always_comb begin
        pickVld = 1'b0;
        pickIdx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(rrPtr) + k) % NREQ]) begin
                pickVld = 1'b1;
                pickIdx = IDX_W'((int'(rrPtr) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/tl_crossing_arbiter.sv
// Shares one TL-UL crossing port among NREQ requesters: A arbitration with lock,
// source-ID widening, D demux by index bits, outstanding counters and idle/error flags.
module tl_crossing_arbiter
    import tl_xing_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int SRC_W   = DEF_SRC_W,
    parameter int MAX_OUT = 4,
    localparam int IDX_W  = $clog2(NREQ),
    localparam int CNT_W  = $clog2(MAX_OUT + 1),
    localparam int AW     = A_SRC_LSB + SRC_W + 5,
    localparam int DW     = D_SRC_LSB + SRC_W + 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NREQ-1:0]        up_a_valid,
    output logic [NREQ-1:0]        up_a_ready,
    input  logic [NREQ*AW-1:0]     up_a_bits,
    output logic                   dn_a_valid,
    input  logic                   dn_a_ready,
    output logic [AW+IDX_W-1:0]    dn_a_bits,
    input  logic                   dn_d_valid,
    output logic                   dn_d_ready,
    input  logic [DW+IDX_W-1:0]    dn_d_bits,
    output logic [NREQ-1:0]        up_d_valid,
    input  logic [NREQ-1:0]        up_d_ready,
    output logic [DW-1:0]          up_d_bits,
    input  logic                   quiesce,
    output logic                   idle,
    output logic                   proto_err
);

    // Valid/ready: a beat transfers on a cycle where valid and ready are both high;
    // once dn_a_valid rises, the granted beat is held unchanged until it transfers.

    localparam int A_IDX_POS = A_SRC_LSB + SRC_W;
    localparam int D_IDX_LSB = D_SRC_LSB + SRC_W;

    logic [CNT_W-1:0] cnt [NREQ];
    logic             lockVld;
    logic [IDX_W-1:0] lockIdx;
    logic [NREQ-1:0]  eligible;
    logic             pickVld;
    logic [IDX_W-1:0] pickIdx;
    logic [IDX_W-1:0] grantIdx;
    logic [AW-1:0]    grantBits;
    logic             aFire;
    logic [IDX_W-1:0] dIdx;
    logic             idxOk;
    logic [CNT_W-1:0] cntSel;
    logic             readySel;
    logic             dLegal;
    logic             dFire;
    logic [NREQ-1:0]  cntInc;
    logic [NREQ-1:0]  cntDec;
    logic             allZero;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = up_a_valid[i] && (cnt[i] < CNT_W'(MAX_OUT)) && !quiesce;
        end
    end

    rr_arbiter_core #(.NREQ(NREQ)) uCore (
        .clock   (clock),
        .reset   (reset),
        .req     (eligible),
        .advance (aFire),
        .advIdx  (grantIdx),
        .pickVld (pickVld),
        .pickIdx (pickIdx)
    );

    // A held lock overrides both the pointer and quiesce.
    assign grantIdx   = lockVld ? lockIdx : pickIdx;
    assign dn_a_valid = !reset && (lockVld || pickVld);
    assign aFire      = dn_a_valid && dn_a_ready;

    always_comb begin
        grantBits = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDX_W'(i) == grantIdx) grantBits = up_a_bits[i*AW +: AW];
        end
    end

    assign dn_a_bits = {grantBits[AW-1:A_IDX_POS], grantIdx, grantBits[A_IDX_POS-1:0]};

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            up_a_ready[i] = aFire && (IDX_W'(i) == grantIdx);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lockVld <= 1'b0;
            lockIdx <= '0;
        end else if (aFire) begin
            lockVld <= 1'b0;
        end else if (dn_a_valid) begin
            lockVld <= 1'b1;
            lockIdx <= grantIdx;
        end
    end

    assign dIdx  = dn_d_bits[D_IDX_LSB +: IDX_W];
    assign idxOk = {1'b0, dIdx} < (IDX_W + 1)'(NREQ);

    always_comb begin
        cntSel   = '0;
        readySel = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDX_W'(i) == dIdx) begin
                cntSel   = cnt[i];
                readySel = up_d_ready[i];
            end
        end
    end

    // Illegal D beats are swallowed here so the crossing never stalls on them.
    assign dLegal     = idxOk && (cntSel != '0);
    assign dn_d_ready = !reset && (dLegal ? readySel : 1'b1);
    assign dFire      = dn_d_valid && dn_d_ready && dLegal;
    assign up_d_bits  = {dn_d_bits[DW+IDX_W-1:D_IDX_LSB+IDX_W], dn_d_bits[D_IDX_LSB-1:0]};

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            up_d_valid[i] = !reset && dn_d_valid && dLegal && (IDX_W'(i) == dIdx);
            cntInc[i]     = aFire && (IDX_W'(i) == grantIdx);
            cntDec[i]     = dFire && (IDX_W'(i) == dIdx);
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NREQ; i++) begin
            if (reset) begin
                cnt[i] <= '0;
            end else if (cntInc[i] && !cntDec[i]) begin
                cnt[i] <= cnt[i] + 1'b1;
            end else if (cntDec[i] && !cntInc[i]) begin
                cnt[i] <= cnt[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            proto_err <= 1'b0;
        end else if (dn_d_valid && !dLegal) begin
            proto_err <= 1'b1;
        end
    end

    always_comb begin
        allZero = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (cnt[i] != '0) allZero = 1'b0;
        end
    end

    assign idle = reset || (!lockVld && allZero);

endmodule

// File: tb/tb_tl_crossing_arbiter.sv
// Directed bench for tl_crossing_arbiter (NREQ=2, SRC_W=8, MAX_OUT=4).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_tl_crossing_arbiter;
    import tl_xing_pkg::*;

    logic         clock;
    logic         reset;
    logic [1:0]   upAValid;
    logic [1:0]   upAReady;
    logic [161:0] upABits;
    logic         dnAValid;
    logic         dnAReady;
    logic [81:0]  dnABits;
    logic         dnDValid;
    logic         dnDReady;
    logic [46:0]  dnDBits;
    logic [1:0]   upDValid;
    logic [1:0]   upDReady;
    logic [45:0]  upDBits;
    logic         quiesce;
    logic         idle;
    logic         protoErr;

    int checks   = 0;
    int failures = 0;
    logic [8:0] expQ[$];
    logic       expPtr;
    logic       g;
    logic [7:0] s0;
    logic [7:0] s1;

    tl_crossing_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .up_a_valid (upAValid),
        .up_a_ready (upAReady),
        .up_a_bits  (upABits),
        .dn_a_valid (dnAValid),
        .dn_a_ready (dnAReady),
        .dn_a_bits  (dnABits),
        .dn_d_valid (dnDValid),
        .dn_d_ready (dnDReady),
        .dn_d_bits  (dnDBits),
        .up_d_valid (upDValid),
        .up_d_ready (upDReady),
        .up_d_bits  (upDBits),
        .quiesce    (quiesce),
        .idle       (idle),
        .proto_err  (protoErr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkEq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [80:0] mkUpA(input logic idx, input logic [7:0] src);
        return {OP_GET, 2'd2, src, {23'h0, idx, src}, 4'hF, 32'h0};
    endfunction

    function automatic logic [81:0] mkDnA(input logic idx, input logic [7:0] src);
        return {OP_GET, 2'd2, idx, src, {23'h0, idx, src}, 4'hF, 32'h0};
    endfunction

    function automatic logic [46:0] mkDnD(input logic [8:0] src);
        return {OP_ACCESS_ACK_DATA, 2'd2, src, 1'b0, {23'h0, src}};
    endfunction

    function automatic logic [45:0] mkUpD(input logic [8:0] src);
        return {OP_ACCESS_ACK_DATA, 2'd2, src[7:0], 1'b0, {23'h0, src}};
    endfunction

    task automatic driveA(input logic [1:0] v, input logic [7:0] a0, input logic [7:0] a1,
                          input logic rdy, input logic q);
        upAValid = v;
        upABits  = {mkUpA(1'b1, a1), mkUpA(1'b0, a0)};
        dnAReady = rdy;
        quiesce  = q;
    endtask

    task automatic driveD(input logic v, input logic [8:0] src, input logic [1:0] rdy);
        dnDValid = v;
        dnDBits  = mkDnD(src);
        upDReady = rdy;
    endtask

    task automatic nextCycle();
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1;
        driveA(2'b11, 8'h01, 8'h02, 1'b1, 1'b0);
        driveD(1'b1, 9'h101, 2'b11);
        repeat (2) nextCycle();
        #1;
        checkEq("rst_dn_a_valid", 128'(dnAValid), 128'(0));
        checkEq("rst_up_a_ready", 128'(upAReady), 128'(0));
        checkEq("rst_dn_d_ready", 128'(dnDReady), 128'(0));
        checkEq("rst_up_d_valid", 128'(upDValid), 128'(0));
        checkEq("rst_idle", 128'(idle), 128'(1));
        nextCycle();
        reset = 1'b0;
        driveA(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
        driveD(1'b0, 9'h000, 2'b11);
        #1;
        checkEq("rst_proto_err", 128'(protoErr), 128'(0));
        checkEq("rst_idle_after", 128'(idle), 128'(1));
        nextCycle();

        // T1: single Get from req0, then its response.
        driveA(2'b01, 8'h05, 8'h00, 1'b1, 1'b0);
        #1;
        checkEq("t1_dn_a_valid", 128'(dnAValid), 128'(1));
        checkEq("t1_dn_a_bits", 128'(dnABits), 128'(mkDnA(1'b0, 8'h05)));
        checkEq("t1_up_a_ready", 128'(upAReady), 128'(2'b01));
        nextCycle();
        driveA(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
        driveD(1'b1, 9'h005, 2'b11);
        #1;
        checkEq("t1_cnt0_one", 128'(dut.cnt[0]), 128'(1));
        checkEq("t1_idle_busy", 128'(idle), 128'(0));
        checkEq("t1_up_d_valid", 128'(upDValid), 128'(2'b01));
        checkEq("t1_dn_d_ready", 128'(dnDReady), 128'(1));
        checkEq("t1_up_d_bits", 128'(upDBits), 128'(mkUpD(9'h005)));
        nextCycle();
        driveD(1'b0, 9'h000, 2'b11);
        #1;
        checkEq("t1_cnt0_zero", 128'(dut.cnt[0]), 128'(0));
        checkEq("t1_idle", 128'(idle), 128'(1));
        expPtr = 1'b1;

        // T2: both requesters always valid, responses returned one cycle later.
        for (int c = 0; c < 4; c++) begin
            s0 = 8'h30 + 8'(c);
            s1 = 8'h40 + 8'(c);
            driveA(2'b11, s0, s1, 1'b1, 1'b0);
            if (expQ.size() > 0) driveD(1'b1, expQ[0], 2'b11);
            else driveD(1'b0, 9'h000, 2'b11);
            #1;
            g = expPtr;
            checkEq($sformatf("t2_grant_bits_%0d", c), 128'(dnABits), 128'(mkDnA(g, g ? s1 : s0)));
            checkEq($sformatf("t2_up_a_ready_%0d", c), 128'(upAReady), 128'(g ? 2'b10 : 2'b01));
            if (expQ.size() > 0) begin
                checkEq($sformatf("t2_up_d_valid_%0d", c), 128'(upDValid),
                        128'(expQ[0][8] ? 2'b10 : 2'b01));
                void'(expQ.pop_front());
            end
            expQ.push_back({g, g ? s1 : s0});
            expPtr = ~g;
            nextCycle();
        end
        driveA(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
        driveD(1'b1, expQ[0], 2'b11);
        #1;
        checkEq("t2_drain_up_d_valid", 128'(upDValid), 128'(expQ[0][8] ? 2'b10 : 2'b01));
        void'(expQ.pop_front());
        nextCycle();
        driveD(1'b0, 9'h000, 2'b11);
        #1;
        checkEq("t2_idle", 128'(idle), 128'(1));

        // T3: req0 held off by backpressure; req1 and quiesce must not disturb it.
        driveA(2'b01, 8'h50, 8'h60, 1'b0, 1'b0);
        #1;
        checkEq("t3_dn_a_valid", 128'(dnAValid), 128'(1));
        checkEq("t3_bits_c0", 128'(dnABits), 128'(mkDnA(1'b0, 8'h50)));
        checkEq("t3_ready_c0", 128'(upAReady), 128'(2'b00));
        nextCycle();
        driveA(2'b11, 8'h50, 8'h60, 1'b0, 1'b1);
        #1;
        checkEq("t3_bits_c1", 128'(dnABits), 128'(mkDnA(1'b0, 8'h50)));
        checkEq("t3_valid_c1", 128'(dnAValid), 128'(1));
        checkEq("t3_ready_c1", 128'(upAReady), 128'(2'b00));
        checkEq("t3_idle_locked", 128'(idle), 128'(0));
        nextCycle();
        driveA(2'b11, 8'h50, 8'h60, 1'b0, 1'b0);
        #1;
        checkEq("t3_bits_c2", 128'(dnABits), 128'(mkDnA(1'b0, 8'h50)));
        nextCycle();
        driveA(2'b11, 8'h50, 8'h60, 1'b1, 1'b0);
        #1;
        checkEq("t3_bits_fire", 128'(dnABits), 128'(mkDnA(1'b0, 8'h50)));
        checkEq("t3_ready_fire", 128'(upAReady), 128'(2'b01));
        nextCycle();
        driveA(2'b10, 8'h50, 8'h60, 1'b1, 1'b0);
        #1;
        checkEq("t3_req1_bits", 128'(dnABits), 128'(mkDnA(1'b1, 8'h60)));
        checkEq("t3_req1_ready", 128'(upAReady), 128'(2'b10));
        nextCycle();
        driveA(2'b11, 8'h51, 8'h61, 1'b1, 1'b1);
        #1;
        checkEq("t3_quiesce_valid", 128'(dnAValid), 128'(0));
        checkEq("t3_quiesce_ready", 128'(upAReady), 128'(2'b00));
        nextCycle();
        driveA(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
        driveD(1'b1, 9'h050, 2'b11);
        #1;
        checkEq("t3_d0_valid", 128'(upDValid), 128'(2'b01));
        nextCycle();
        driveD(1'b1, 9'h160, 2'b11);
        #1;
        checkEq("t3_d1_valid", 128'(upDValid), 128'(2'b10));
        nextCycle();
        driveD(1'b0, 9'h000, 2'b11);
        #1;
        checkEq("t3_idle", 128'(idle), 128'(1));

        // T4: req1 fills its MAX_OUT budget; req0 keeps being served.
        for (int c = 0; c < 4; c++) begin
            driveA(2'b10, 8'h00, 8'h70 + 8'(c), 1'b1, 1'b0);
            #1;
            checkEq($sformatf("t4_fill_ready_%0d", c), 128'(upAReady), 128'(2'b10));
            nextCycle();
        end
        driveA(2'b11, 8'h80, 8'h74, 1'b1, 1'b0);
        #1;
        checkEq("t4_req0_ready", 128'(upAReady), 128'(2'b01));
        checkEq("t4_req0_bits", 128'(dnABits), 128'(mkDnA(1'b0, 8'h80)));
        nextCycle();
        driveA(2'b10, 8'h00, 8'h74, 1'b1, 1'b0);
        #1;
        checkEq("t4_blocked_valid", 128'(dnAValid), 128'(0));
        checkEq("t4_blocked_ready", 128'(upAReady), 128'(2'b00));
        checkEq("t4_cnt1_full", 128'(dut.cnt[1]), 128'(4));
        nextCycle();
        driveD(1'b1, 9'h170, 2'b11);
        #1;
        checkEq("t4_d_up_valid", 128'(upDValid), 128'(2'b10));
        checkEq("t4_still_blocked", 128'(upAReady), 128'(2'b00));
        nextCycle();
        driveD(1'b0, 9'h000, 2'b11);
        #1;
        checkEq("t4_unblocked", 128'(upAReady), 128'(2'b10));
        nextCycle();
        driveA(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            driveD(1'b1, 9'h171 + 9'(c), 2'b11);
            #1;
            checkEq($sformatf("t4_drain1_%0d", c), 128'(upDValid), 128'(2'b10));
            nextCycle();
        end
        driveD(1'b1, 9'h080, 2'b11);
        #1;
        checkEq("t4_drain0", 128'(upDValid), 128'(2'b01));
        nextCycle();
        driveD(1'b0, 9'h000, 2'b11);
        #1;
        checkEq("t4_idle", 128'(idle), 128'(1));

        // T5: A fire and D fire on req0 in the same cycle.
        for (int c = 0; c < 2; c++) begin
            driveA(2'b01, 8'h90 + 8'(c), 8'h00, 1'b1, 1'b0);
            #1;
            checkEq($sformatf("t5_issue_%0d", c), 128'(upAReady), 128'(2'b01));
            nextCycle();
        end
        driveA(2'b01, 8'h92, 8'h00, 1'b1, 1'b0);
        driveD(1'b1, 9'h090, 2'b11);
        #1;
        checkEq("t5_cnt0_before", 128'(dut.cnt[0]), 128'(2));
        checkEq("t5_a_ready", 128'(upAReady), 128'(2'b01));
        checkEq("t5_d_valid", 128'(upDValid), 128'(2'b01));
        nextCycle();
        driveA(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
        driveD(1'b0, 9'h000, 2'b11);
        #1;
        checkEq("t5_cnt0_hold", 128'(dut.cnt[0]), 128'(2));
        nextCycle();
        driveD(1'b1, 9'h091, 2'b11);
        nextCycle();
        driveD(1'b1, 9'h092, 2'b11);
        nextCycle();
        driveD(1'b0, 9'h000, 2'b11);
        #1;
        checkEq("t5_cnt0_zero", 128'(dut.cnt[0]), 128'(0));
        checkEq("t5_idle", 128'(idle), 128'(1));

        // T6: response for a requester with nothing outstanding.
        driveD(1'b1, 9'h1FF, 2'b00);
        #1;
        checkEq("t6_dn_d_ready", 128'(dnDReady), 128'(1));
        checkEq("t6_up_d_valid", 128'(upDValid), 128'(2'b00));
        checkEq("t6_err_not_yet", 128'(protoErr), 128'(0));
        nextCycle();
        driveD(1'b0, 9'h000, 2'b11);
        #1;
        checkEq("t6_proto_err", 128'(protoErr), 128'(1));
        checkEq("t6_cnt1", 128'(dut.cnt[1]), 128'(0));
        nextCycle();
        #1;
        checkEq("t6_err_sticky", 128'(protoErr), 128'(1));
        reset = 1'b1;
        nextCycle();
        #1;
        checkEq("t6_err_cleared", 128'(protoErr), 128'(0));
        checkEq("t6_idle_reset", 128'(idle), 128'(1));
        reset = 1'b0;
        nextCycle();
        #1;
        checkEq("t6_idle_after", 128'(idle), 128'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
